// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared HI/LO opcode enum and decode helpers for the HI/LO multiply/divide controller.
package hilo_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MFHI  = 4'd1,
    OP_MFLO  = 4'd2,
    OP_MTHI  = 4'd3,
    OP_MTLO  = 4'd4,
    OP_MULT  = 4'd5,
    OP_MULTU = 4'd6,
    OP_DIV   = 4'd7,
    OP_DIVU  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } hilo_op_t;

  typedef enum logic [1:0] {
    ACC_SET = 2'd0,
    ACC_ADD = 2'd1,
    ACC_SUB = 2'd2
  } acc_mode_t;

  function automatic logic is_mul_op(hilo_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(hilo_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(hilo_op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic acc_mode_t acc_mode_of(hilo_op_t op);
    case (op)
      OP_MADD, OP_MADDU: return ACC_ADD;
      OP_MSUB, OP_MSUBU: return ACC_SUB;
      default:           return ACC_SET;
    endcase
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_acc.sv
// Combinational {HI,LO} update: replace with, add or subtract the product (64-bit wrap).
module hilo_acc
  import hilo_mdu_ctrl_pkg::*;
(
  input  logic [63:0] i_hilo,
  input  logic [63:0] i_prod,
  input  acc_mode_t   i_mode,
  output logic [63:0] o_hilo
);

  always_comb begin
    o_hilo = i_prod;
    case (i_mode)
      ACC_ADD: o_hilo = i_hilo + i_prod;
      ACC_SUB: o_hilo = i_hilo - i_prod;
      default: o_hilo = i_prod;
    endcase
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner: sequences MF/MT, fixed-latency multiply(-accumulate) and iterative divide from EX.
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_ex_stall,
  input  logic        i_op_valid,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_reg1,
  input  logic [31:0] i_reg2,
  output logic [31:0] o_mf_data,
  output logic        o_stall_req,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  output logic        o_mul_signed,
  input  logic [63:0] i_mul_result,
  output logic        o_div_start,
  output logic        o_div_signed,
  output logic        o_div_abort,
  output logic [31:0] o_div_a,
  output logic [31:0] o_div_b,
  input  logic        i_div_done,
  input  logic [31:0] i_div_quot,
  input  logic [31:0] i_div_rem,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} hilo_state_t;

  localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LATENCY - 1);

  hilo_state_t   r_state, w_next;
  logic [CW-1:0] r_cnt;
  acc_mode_t     r_acc_mode;
  logic          r_div_first;
  logic [31:0]   r_mul_a, r_mul_b, r_div_a, r_div_b, r_hi, r_lo;
  logic          r_mul_signed, r_div_signed;

  hilo_op_t      w_op;
  logic [63:0]   w_acc;
  logic [31:0]   w_mf;
  logic          w_stall, w_start, w_abort;
  logic          w_ld_mul, w_ld_div, w_wr_hi, w_wr_lo, w_commit_mul, w_commit_div;

  assign w_op = hilo_op_t'(i_op);

  hilo_acc u_acc (
    .i_hilo (({r_hi, r_lo})),
    .i_prod (i_mul_result),
    .i_mode (r_acc_mode),
    .o_hilo (w_acc)
  );

  always_comb begin
    w_next       = r_state;
    w_mf         = '0;
    w_stall      = 1'b0;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_ld_mul     = 1'b0;
    w_ld_div     = 1'b0;
    w_wr_hi      = 1'b0;
    w_wr_lo      = 1'b0;
    w_commit_mul = 1'b0;
    w_commit_div = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_op_valid) begin
          if (w_op == OP_MFHI) w_mf = r_hi;
          if (w_op == OP_MFLO) w_mf = r_lo;
          if (!i_flush) begin
            if (w_op == OP_MTHI) w_wr_hi = 1'b1;
            if (w_op == OP_MTLO) w_wr_lo = 1'b1;
            if (is_mul_op(w_op)) begin
              w_stall  = 1'b1;
              w_ld_mul = 1'b1;
              w_next   = S_MUL;
            end
            if (is_div_op(w_op)) begin
              w_stall = 1'b1;
              if (i_reg2 == '0) begin
                w_next = S_DONE;
              end else begin
                w_ld_div = 1'b1;
                w_next   = S_DIV;
              end
            end
          end
        end
      end
      S_MUL: begin
        if (i_flush) begin
          w_next = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == '0) begin
            w_commit_mul = 1'b1;
            w_next       = S_DONE;
          end
        end
      end
      S_DIV: begin
        // A flush in the start cycle suppresses the start, so start/abort stay exclusive.
        if (i_flush) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_start = r_div_first;
          w_stall = 1'b1;
          if (i_div_done) begin
            w_commit_div = 1'b1;
            w_next       = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_flush || !i_ex_stall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acc_mode   <= ACC_SET;
      r_div_first  <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_signed <= 1'b0;
      r_div_a      <= '0;
      r_div_b      <= '0;
      r_div_signed <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      r_state     <= w_next;
      r_div_first <= w_ld_div;
      if (w_ld_mul) begin
        r_mul_a      <= i_reg1;
        r_mul_b      <= i_reg2;
        r_mul_signed <= is_signed_op(w_op);
        r_acc_mode   <= acc_mode_of(w_op);
        r_cnt        <= CNT_INIT;
      end else if (r_state == S_MUL && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_ld_div) begin
        r_div_a      <= i_reg1;
        r_div_b      <= i_reg2;
        r_div_signed <= is_signed_op(w_op);
      end
      if (w_wr_hi) r_hi <= i_reg1;
      if (w_wr_lo) r_lo <= i_reg1;
      if (w_commit_mul) {r_hi, r_lo} <= w_acc;
      if (w_commit_div) begin
        r_lo <= i_div_quot;
        r_hi <= i_div_rem;
      end
    end
  end

  assign o_mf_data    = i_rst ? '0 : w_mf;
  assign o_stall_req  = w_stall & ~i_rst;
  assign o_div_start  = w_start & ~i_rst;
  assign o_div_abort  = w_abort & ~i_rst;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_mul_signed = r_mul_signed;
  assign o_div_a      = r_div_a;
  assign o_div_b      = r_div_b;
  assign o_div_signed = r_div_signed;
  assign o_hi         = r_hi;
  assign o_lo         = r_lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Randomized self-checking bench for hilo_mdu_ctrl with behavioural HI/LO model, multiplier and divider.
module tb_hilo_mdu_ctrl;
  import hilo_mdu_ctrl_pkg::*;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, ex_stall = 1'b0, op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] reg1 = '0, reg2 = '0;
  logic [31:0] mf_data, mul_a, mul_b, div_a, div_b, hi, lo;
  logic        stall_req, mul_signed, div_start, div_signed, div_abort;
  logic [63:0] mul_result;
  logic        div_done = 1'b0;
  logic [31:0] div_quot = '0, div_rem = '0;

  hilo_mdu_ctrl #(.MUL_LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_ex_stall(ex_stall),
    .i_op_valid(op_valid), .i_op(op), .i_reg1(reg1), .i_reg2(reg2),
    .o_mf_data(mf_data), .o_stall_req(stall_req),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_signed(mul_signed),
    .i_mul_result(mul_result),
    .o_div_start(div_start), .o_div_signed(div_signed), .o_div_abort(div_abort),
    .o_div_a(div_a), .o_div_b(div_b),
    .i_div_done(div_done), .i_div_quot(div_quot), .i_div_rem(div_rem),
    .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int n_stall_cyc = 0, n_start = 0, n_abort = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // External multiplier: LAT-cycle pipe (combinational product + LAT-1 registers)
  logic [63:0] mprod, mreg1 = '0, mreg2 = '0;
  always_comb begin
    if (mul_signed) mprod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else            mprod = {32'b0, mul_a} * {32'b0, mul_b};
  end
  always @(posedge clk) begin
    mreg1 <= mprod;
    mreg2 <= mreg1;
  end
  assign mul_result = mreg2;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    if (sgn) return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
    return {a % b, a / b};
  endfunction

  // External divider: div_done exactly g_div_delay cycles after the start cycle
  int unsigned g_div_delay = 2;
  int unsigned dv_cnt = 0;
  logic        dv_busy = 1'b0;
  always @(posedge clk) begin
    if (rst || div_abort) begin
      dv_busy  <= 1'b0;
      div_done <= 1'b0;
    end else if (div_done) begin
      div_done <= 1'b0;
      dv_busy  <= 1'b0;
    end else if (div_start) begin
      {div_rem, div_quot} <= ref_div(div_a, div_b, div_signed);
      dv_busy <= 1'b1;
      if (g_div_delay <= 1) div_done <= 1'b1;
      else dv_cnt <= g_div_delay - 1;
    end else if (dv_busy) begin
      if (dv_cnt == 1) div_done <= 1'b1;
      dv_cnt <= dv_cnt - 1;
    end
  end

  // Behavioural architectural state and per-cycle expectations
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        e_stall = 1'b0, e_start = 1'b0, e_abort = 1'b0;
  logic [31:0] e_mf = '0;
  logic        e_mul_chk = 1'b0, e_div_chk = 1'b0, e_sgn = 1'b0;
  logic [31:0] e_a = '0, e_b = '0;
  logic        chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_req", 64'(stall_req), 64'(e_stall));
      chk("mf_data", 64'(mf_data), 64'(e_mf));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("div_start", 64'(div_start), 64'(e_start));
      chk("div_abort", 64'(div_abort), 64'(e_abort));
      if (e_mul_chk) begin
        chk("mul_a", 64'(mul_a), 64'(e_a));
        chk("mul_b", 64'(mul_b), 64'(e_b));
        chk("mul_signed", 64'(mul_signed), 64'(e_sgn));
      end
      if (e_div_chk) begin
        chk("div_a", 64'(div_a), 64'(e_a));
        chk("div_b", 64'(div_b), 64'(e_b));
        chk("div_signed", 64'(div_signed), 64'(e_sgn));
      end
    end
    if (stall_req) n_stall_cyc++;
    if (div_start) n_start++;
    if (div_abort) n_abort++;
  end

  function automatic logic [63:0] ref_mul(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    longint p;
    if (o == OP_MULT || o == OP_MADD || o == OP_MSUB) p = longint'(int'(a)) * longint'(int'(b));
    else p = longint'({32'b0, a}) * longint'({32'b0, b});
    if (o == OP_MADD || o == OP_MADDU) return acc + 64'(p);
    if (o == OP_MSUB || o == OP_MSUBU) return acc - 64'(p);
    return 64'(p);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_stall = 0; e_mf = '0; e_start = 0; e_abort = 0; e_mul_chk = 0; e_div_chk = 0;
  endtask

  task automatic done_phase(input int unsigned hold);
    e_stall = 0; e_start = 0; e_mul_chk = 0; e_div_chk = 0;
    ex_stall = 1;
    repeat (hold) cyc();
    ex_stall = 0;
    cyc();
    op_valid = 0;
  endtask

  // One instruction held in EX until released; flush_at (1-based) flushes in that MUL/DIV cycle
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned ddly, input int unsigned flush_at, input int unsigned hold);
    logic sgn;
    idle_exp();
    op_valid = 1; op = o; reg1 = a; reg2 = b; flush = 0; ex_stall = 0; g_div_delay = ddly;
    sgn = (o == OP_MULT || o == OP_DIV || o == OP_MADD || o == OP_MSUB);
    if (o == OP_MFHI || o == OP_MFLO) begin
      e_mf = (o == OP_MFHI) ? m_hi : m_lo;
      cyc();
    end else if (o == OP_MTHI || o == OP_MTLO) begin
      cyc();
      if (o == OP_MTHI) m_hi = a; else m_lo = a;
    end else if (o == OP_DIV || o == OP_DIVU) begin
      e_stall = 1;
      cyc();
      if (b == 0) begin
        done_phase(hold);
      end else begin
        e_div_chk = 1; e_a = a; e_b = b; e_sgn = sgn;
        for (int unsigned j = 1; j <= ddly + 1; j++) begin
          e_start = (j == 1);
          if (j == flush_at) begin
            flush = 1; e_stall = 0; e_start = 0; e_abort = 1;
            cyc();
            flush = 0; op_valid = 0; idle_exp();
            return;
          end
          e_stall = 1;
          cyc();
        end
        {m_hi, m_lo} = ref_div(a, b, sgn);
        done_phase(hold);
      end
    end else begin
      e_stall = 1;
      cyc();
      e_mul_chk = 1; e_a = a; e_b = b; e_sgn = sgn;
      for (int unsigned j = 1; j <= LAT; j++) begin
        if (j == flush_at) begin
          flush = 1; e_stall = 0;
          cyc();
          flush = 0; op_valid = 0; idle_exp();
          return;
        end
        e_stall = 1;
        cyc();
      end
      {m_hi, m_lo} = ref_mul(o, a, b, {m_hi, m_lo});
      done_phase(hold);
    end
    op_valid = 0;
    idle_exp();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, st0, ab0;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    rst = 1;
    repeat (2) cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    cyc();
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_mul_a", 64'(mul_a), 64'h0);
    chk("reset_div_b", 64'(div_b), 64'h0);

    s0 = n_stall_cyc;
    issue(OP_MTHI, 32'h12345678, 32'h0, 2, 0, 0);
    chk("mthi_value", 64'(hi), 64'h12345678);
    issue(OP_MFHI, 32'h0, 32'h0, 2, 0, 0);
    chk("mt_mf_no_stall", 64'(n_stall_cyc - s0), 64'd0);

    s0 = n_stall_cyc;
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 2, 0, 0);
    chk("mult_stall_cycles", 64'(n_stall_cyc - s0), 64'd4);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFFA);

    issue(OP_MTHI, 32'hFFFFFFFF, 32'h0, 2, 0, 0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0, 2, 0, 0);
    issue(OP_MADDU, 32'd1, 32'd2, 2, 0, 0);
    chk("maddu_wrap_hi", 64'(hi), 64'h0);
    chk("maddu_wrap_lo", 64'(lo), 64'h1);

    st0 = n_start;
    issue(OP_DIVU, 32'd100, 32'd7, 5, 0, 0);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_one_start", 64'(n_start - st0), 64'd1);

    s0 = n_stall_cyc; st0 = n_start;
    issue(OP_DIVU, 32'd55, 32'd0, 3, 0, 0);
    chk("divz_stall_cycles", 64'(n_stall_cyc - s0), 64'd1);
    chk("divz_no_start", 64'(n_start - st0), 64'd0);
    chk("divz_lo_kept", 64'(lo), 64'd14);

    ab0 = n_abort;
    issue(OP_DIVU, 32'd50, 32'd3, 3, 4, 0);
    chk("flush_div_abort", 64'(n_abort - ab0), 64'd1);
    chk("flush_div_hi_kept", 64'(hi), 64'd2);
    chk("flush_div_lo_kept", 64'(lo), 64'd14);

    st0 = n_start;
    issue(OP_DIVU, 32'd9, 32'd2, 2, 0, 3);
    chk("done_hold_one_start", 64'(n_start - st0), 64'd1);
    chk("done_hold_lo", 64'(lo), 64'd4);

    // Reset in the middle of a divide: no abort, HI/LO cleared
    ab0 = n_abort;
    idle_exp();
    op_valid = 1; op = OP_DIVU; reg1 = 32'd20; reg2 = 32'd3; g_div_delay = 4;
    e_stall = 1; cyc();
    e_start = 1; cyc();
    e_start = 0; cyc();
    rst = 1; op_valid = 0; e_stall = 0; cyc();
    rst = 0; m_hi = '0; m_lo = '0; cyc();
    chk("reset_mid_div_no_abort", 64'(n_abort - ab0), 64'd0);
    chk("reset_mid_div_hi", 64'(hi), 64'h0);

    for (int i = 0; i < 120; i++) begin
      ro = 4'($urandom_range(1, 12));
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
      if ((ro == OP_DIV || ro == OP_DIVU) && $urandom_range(0, 5) == 0) rb = '0;
      if (ro == OP_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      issue(ro, ra, rb, $urandom_range(1, 5),
            ($urandom_range(0, 6) == 0) ? $urandom_range(1, 5) : 0, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) cyc();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
# hilo_mdu_ctrl

- Controller that owns the architectural HI/LO register pair.
- Sequences every HI/LO-class instruction from the EX stage: MFHI/MFLO, MTHI/MTLO, MULT(U), DIV(U), MADD(U)/MSUB(U).
- Drives an external fixed-latency multiplier and an external start/done iterative divider.
- Holds EX with `stall_req` until the result is committed; the issue stage already guarantees at most one HI/LO instruction per cycle.

## Interface
- `MUL_LATENCY`, default 3: cycles from registered multiplier operands to valid `mul_result`; must be ≥1.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kills any in-flight op (exception or mispredict squash).
- `ex_stall`  in  1  EX is held by another source.
- `op_valid`  in  1  EX holds a HI/LO-class instruction.
- `op`  in  4  `hilo_op_t` opcode.
- `reg1`, `reg2`  in  32 each  rs/rt operand values.
- `mf_data`  out  32  HI (MFHI) or LO (MFLO); 0 otherwise.
- `stall_req`  out  1  holds EX.
- `mul_a`, `mul_b`  out  32 each  registered multiplier operands.
- `mul_signed`  out  1  signed multiply.
- `mul_result`  in  64  product.
- `div_start`  out  1  one-cycle divider start pulse.
- `div_signed`  out  1  signed divide.
- `div_abort`  out  1  one-cycle divider cancel pulse.
- `div_a`, `div_b`  out  32 each  dividend/divisor, stable while the divider is busy.
- `div_done`  in  1  divider result valid.
- `div_quot`, `div_rem`  in  32 each  divider result.
- `hi`, `lo`  out  32 each  architectural HI/LO.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **IDLE, no `op_valid`:** no action.
- **IDLE, MTHI/MTLO:** write `reg1` into HI or LO at the edge; `stall_req`=0; state stays IDLE.
- **IDLE, MFHI/MFLO:** `mf_data` = current `hi`/`lo`, combinational; `stall_req`=0.
- **IDLE, MULT/MULTU/MADD*/MSUB*:**
  - Register `reg1`/`reg2` into `mul_a`/`mul_b`.
  - Load counter with `MUL_LATENCY`-1 and go to MUL.
  - `stall_req`=1 in the accept cycle.
- **IDLE, DIV/DIVU:**
  - Register `div_a`/`div_b` and go to DIV.
  - `div_start` pulses in the first DIV cycle.
  - `stall_req`=1 in the accept cycle.
- **IDLE, DIV/DIVU with `reg2`==0:** no `div_start`; go straight to DONE; HI/LO unchanged.
- **MUL:** `stall_req`=1; counter decrements.
  - When counter==0, commit at the edge and go to DONE.
  - MULT(U): {HI,LO} = `mul_result`.
  - MADD(U): {HI,LO} += `mul_result`; MSUB(U): {HI,LO} −= `mul_result`. Both use 64-bit wrap-around arithmetic.
- **DIV:** `stall_req`=1.
  - On `div_done`: LO=`div_quot`, HI=`div_rem`; go to DONE.
- **DONE:** `stall_req`=0; the held `op_valid` is consumed and ignored.
  - Leave DONE for IDLE only when `ex_stall`=0; otherwise stay in DONE.
- **`flush` in any state:**
  - Next state IDLE; HI/LO not written; `stall_req`=0 that cycle.
  - Pulse `div_abort` if flushed in DIV.
  - `flush` beats a same-cycle commit (counter==0 or `div_done`). The result is dropped.
- **Operand signedness:** `mul_signed`/`div_signed` = opcode is a signed variant; latched with the operands.

## Timing
- **Reset values:** state IDLE; `hi`=`lo`=0; all other outputs 0.
- **MT write:** visible on `hi`/`lo` the cycle after acceptance.
- **Multiply:** total `stall_req` cycles = 1+`MUL_LATENCY`; commit at the end of the last MUL cycle. MFHI/MFLO issued after DONE reads the new value.
- **Divide:** `stall_req` cycles = 1 + cycles until `div_done`, with `div_done` at the earliest in the second DIV cycle.
- **Divide by zero:** exactly 1 stall cycle.
- **`div_start`/`div_abort`:** never asserted in the same cycle.
- **`mul_a`/`mul_b`:** held constant throughout MUL.
- **Reset mid-operation:** as `flush`, plus HI/LO cleared; no `div_abort` emitted.

## Structure
- `hilo_op_t` enum (NONE, MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU) goes in `cpu_defs.svh`. The decoder fills it.
- `hilo_state_t` is local to the module.
- One sub-module, `hilo_acc`: combinational 64-bit {HI,LO}±product / replace selector, keeping the FSM file small.

## Test plan
- **MTHI/MFHI:** reset; MTHI `reg1`=0x12345678 → `hi`=0x12345678 next cycle, `stall_req` never 1; MFHI next → `mf_data`=0x12345678.
- **MULT signed, `MUL_LATENCY`=3:** `reg1`=0xFFFFFFFE (−2), `reg2`=3 → `stall_req` high for 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; DONE lasts 1 cycle.
- **MADDU wrap:** {HI,LO} preset 0xFFFFFFFF_FFFFFFFF, `reg1`=1, `reg2`=2 → HI=0, LO=1.
- **DIVU:** 100/7 with `div_done` 5 cycles after start → LO=14, HI=2, one `div_start` pulse.
- **DIVU by zero:** 1 stall cycle, HI/LO unchanged.
- **Flush in DIV:** `flush` asserted together with `div_done` → HI/LO unchanged, `div_abort`=1 one cycle, state IDLE next. `ex_stall`=1 held in DONE for 3 cycles with `op_valid`=1 → no restart, no extra `div_start`.
